mem_fill_responder: RTL and testbench

MEM_FILL_RESPONDER -- requirements
Module: mem_fill_responder

---
 rtl/mem_fill_responder.sv | 67 ++++++
 tb/tb_mem_fill_responder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mem_fill_responder.sv
// Word-addressed 16-bit storage that answers reads after a fixed LATENCY.
// Each read snapshots its word at issue and carries it down a shift pipeline.
module mem_fill_responder #(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        wr,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic        data_valid,
    output logic [2:0]  outstanding
);
    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [DEPTH];
    logic [15:0]           addr_word;
    logic [DEPTH_LOG2-1:0] word_idx;
    logic                  unused_addr_bits;
    logic                  read_issue;
    logic                  write_issue;
    logic [LATENCY-1:0]    pipe_valid;
    logic [15:0]           pipe_data [LATENCY];

    // Byte address to word index; high bits are dropped so large addresses wrap.
    assign addr_word        = {1'b0, addr[15:1]};
    assign word_idx         = addr_word[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^{addr_word[15:DEPTH_LOG2], addr[0]};

    assign read_issue  = enable & ~wr;
    assign write_issue = enable & wr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 16'h0000;
            end
        end else if (write_issue) begin
            mem[word_idx] <= data_in;
        end
    end

    // Empty slots carry zero data so the last stage can drive data_out directly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_valid  <= '0;
            outstanding <= 3'd0;
            for (int i = 0; i < LATENCY; i++) begin
                pipe_data[i] <= 16'h0000;
            end
        end else begin
            pipe_valid[0] <= read_issue;
            pipe_data[0]  <= read_issue ? mem[word_idx] : 16'h0000;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_data[i]  <= pipe_data[i-1];
            end
            outstanding <= outstanding + {2'b00, read_issue} - {2'b00, pipe_valid[LATENCY-1]};
        end
    end

    assign data_valid = pipe_valid[LATENCY-1];
    assign data_out   = pipe_data[LATENCY-1];
endmodule

// File: tb/tb_mem_fill_responder.sv
// Bench for mem_fill_responder: a LATENCY=4 instance driven from a vector table
// plus directed sequences, and a LATENCY=1 instance for the short-pipeline case.
module tb_mem_fill_responder;
    typedef struct {
        logic        en;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        exp_valid;
        logic [15:0] exp_data;
        logic [2:0]  exp_out;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        enable, wr;
    logic [15:0] addr, data_in, data_out;
    logic        data_valid;
    logic [2:0]  outstanding;
    logic        enable_l1, wr_l1;
    logic [15:0] addr_l1, data_in_l1, data_out_l1;
    logic        data_valid_l1;
    logic [2:0]  outstanding_l1;

    int   tests_run    = 0;
    int   tests_failed = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    mem_fill_responder #(.LATENCY(4), .DEPTH_LOG2(9)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .wr(wr), .addr(addr),
        .data_in(data_in), .data_out(data_out), .data_valid(data_valid),
        .outstanding(outstanding)
    );

    mem_fill_responder #(.LATENCY(1), .DEPTH_LOG2(9)) dut_l1 (
        .clk(clk), .rst_n(rst_n), .enable(enable_l1), .wr(wr_l1), .addr(addr_l1),
        .data_in(data_in_l1), .data_out(data_out_l1), .data_valid(data_valid_l1),
        .outstanding(outstanding_l1)
    );

    function automatic vec_t mk(input logic en, input logic w, input logic [15:0] a,
                                input logic [15:0] d, input logic ev,
                                input logic [15:0] ed, input logic [2:0] eo);
        vec_t v;
        v.en = en; v.wr = w; v.addr = a; v.din = d;
        v.exp_valid = ev; v.exp_data = ed; v.exp_out = eo;
        return v;
    endfunction

    // Drives one request on the selected instance, then samples 2ns after the edge.
    task automatic applyStimulus(input bit lat1, input logic en, input logic w,
                                 input logic [15:0] a, input logic [15:0] d);
        if (lat1) begin
            enable_l1 = en; wr_l1 = w; addr_l1 = a; data_in_l1 = d;
            enable = 1'b0;
        end else begin
            enable = en; wr = w; addr = a; data_in = d;
            enable_l1 = 1'b0;
        end
        @(posedge clk);
        #2;
    endtask

    task automatic checkOutput(input string name, input logic [15:0] actual,
                               input logic [15:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic checkAll4(input string tag, input logic ev, input logic [15:0] ed,
                             input logic [2:0] eo);
        checkOutput({tag, " data_valid"}, {15'd0, data_valid}, {15'd0, ev});
        checkOutput({tag, " data_out"}, data_out, ed);
        checkOutput({tag, " outstanding"}, {13'd0, outstanding}, {13'd0, eo});
    endtask

    task automatic checkAll1(input string tag, input logic ev, input logic [15:0] ed,
                             input logic [2:0] eo);
        checkOutput({tag, " l1 data_valid"}, {15'd0, data_valid_l1}, {15'd0, ev});
        checkOutput({tag, " l1 data_out"}, data_out_l1, ed);
        checkOutput({tag, " l1 outstanding"}, {13'd0, outstanding_l1}, {13'd0, eo});
    endtask

    initial begin
        logic [2:0] fill_out [12] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4,
                                      3'd4, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
        logic        fv;
        logic [15:0] fd;

        rst_n = 1'b0;
        enable = 1'b0; wr = 1'b0; addr = 16'h0000; data_in = 16'h0000;
        enable_l1 = 1'b0; wr_l1 = 1'b0; addr_l1 = 16'h0000; data_in_l1 = 16'h0000;

        // Single read after reset: returns zero on the 4th sample.
        vecs.push_back(mk(1'b1, 1'b0, 16'h0010, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0));
        // Block fill: 8 writes, 8 back-to-back reads, then drain.
        for (int i = 0; i < 8; i++) begin
            vecs.push_back(mk(1'b1, 1'b1, 16'(16'h0100 + 2 * i), 16'(16'hA000 + i),
                              1'b0, 16'h0000, 3'd0));
        end
        for (int r = 0; r < 12; r++) begin
            fv = (r >= 3) && (r < 11);
            fd = fv ? 16'(16'hA000 + r - 3) : 16'h0000;
            vecs.push_back(mk(r < 8, 1'b0, 16'(16'h0100 + 2 * (r % 8)), 16'h0000,
                              fv, fd, fill_out[r]));
        end
        // Hazards: write-then-read, and write over an in-flight read.
        vecs.push_back(mk(1'b1, 1'b1, 16'h0002, 16'h1234, 1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 16'h0000, 3'd2));
        vecs.push_back(mk(1'b1, 1'b1, 16'h0004, 16'hFFFF, 1'b0, 16'h0000, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0));
        // Wrap: 0x0402 aliases 0x0002; a disabled write must not land.
        vecs.push_back(mk(1'b1, 1'b1, 16'h0402, 16'h5A5A, 1'b0, 16'h0000, 3'd0));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0003, 16'h0000, 1'b0, 16'h0000, 3'd2));
        vecs.push_back(mk(1'b0, 1'b1, 16'h0002, 16'hDEAD, 1'b0, 16'h0000, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 3'd2));
        vecs.push_back(mk(1'b1, 1'b0, 16'h0002, 16'h0000, 1'b1, 16'h5A5A, 3'd2));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h5A5A, 3'd1));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 3'd0));

        repeat (2) @(posedge clk);
        #2;
        checkAll4("reset", 1'b0, 16'h0000, 3'd0);
        checkAll1("reset", 1'b0, 16'h0000, 3'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(1'b0, vecs[i].en, vecs[i].wr, vecs[i].addr, vecs[i].din);
            checkAll4($sformatf("vec%0d", i), vecs[i].exp_valid, vecs[i].exp_data,
                      vecs[i].exp_out);
        end

        // Reset with three reads in flight, requests held during reset.
        applyStimulus(1'b0, 1'b1, 1'b1, 16'h0020, 16'h7777);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0022, 16'h0000);
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0024, 16'h0000);
        checkAll4("pre-reset", 1'b0, 16'h0000, 3'd3);
        enable = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checkAll4("async reset", 1'b0, 16'h0000, 3'd0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
            checkAll4($sformatf("in reset%0d", i), 1'b0, 16'h0000, 3'd0);
        end
        rst_n = 1'b1;
        applyStimulus(1'b0, 1'b1, 1'b0, 16'h0020, 16'h0000);
        checkAll4("post-reset r0", 1'b0, 16'h0000, 3'd1);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
            checkAll4($sformatf("post-reset r%0d", i), i == 3, 16'h0000,
                      (i <= 3) ? 3'd1 : 3'd0);
        end

        // LATENCY=1: alternate write/read, each read returns on the next sample.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) begin
                applyStimulus(1'b1, 1'b1, 1'b1, 16'(2 * i), 16'(16'hC000 + i));
                checkAll1($sformatf("alt%0d", i), 1'b0, 16'h0000, 3'd0);
            end else begin
                applyStimulus(1'b1, 1'b1, 1'b0, 16'(2 * (i - 1)), 16'h0000);
                checkAll1($sformatf("alt%0d", i), 1'b1, 16'(16'hC000 + i - 1), 3'd1);
            end
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 16'(4 * i), 16'h0000);
            checkAll1($sformatf("burst%0d", i), 1'b1, 16'(16'hC000 + 2 * i), 3'd1);
        end
        applyStimulus(1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checkAll1("burst drain", 1'b0, 16'h0000, 3'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
